// File: rtl/step_clk_debouncer.sv
// Single-step push-button to CPU clock converter.
// Path: 2-FF synchronizer -> debounce FSM -> fixed-width CPUCLK stretcher.
// Also provides a one-cycle step strobe, the debounced level and a wrapping
// 16-bit step counter.
// Optional macro STEP_AUTOREPEAT_EN: a held button keeps issuing steps
// (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
module step_clk_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned PULSE_CYCLES    = 50000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 20000000
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Button,
    output logic        CPUCLK,
    output logic        StepPulse,
    output logic        ButtonLevel,
    output logic [15:0] StepCount
);

    // Pulse timer holds the remaining high cycles after the firing edge (max PULSE_CYCLES-1).
    localparam int unsigned PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    // Reject illegal configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || PULSE_CYCLES < 1 || PULSE_CYCLES >= DEBOUNCE_CYCLES ||
        (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES) || REPEAT_PERIOD <= PULSE_CYCLES ||
        REPEAT_DELAY < 1) begin : g_bad_params
        $error("step_clk_debouncer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               cpuclk_q, cpuclk_d;
    logic               step_q, step_d;
    logic               level_q, level_d;
    logic [15:0]        count_q, count_d;
    logic               fire_step;

`ifdef STEP_AUTOREPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rep_q, rep_d;
`endif

    // Next-state logic: synchronizer, debounce FSM, step firing and CPUCLK stretcher.
    always_comb begin
        sync1_d   = Button;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        fire_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d   = PRESSED;
                    fire_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef STEP_AUTOREPEAT_EN
        // Hold timer only advances while staying in PRESSED; any other cycle
        // (including the entry edge) clears it, so re-entry restarts the delay.
        hold_d = '0;
        rep_d  = 1'b0;
        if (state_q == PRESSED && sync2_q) begin
            if ((!rep_q && hold_q == HOLD_W'(REPEAT_DELAY - 1)) ||
                ( rep_q && hold_q == HOLD_W'(REPEAT_PERIOD - 1))) begin
                fire_step = 1'b1;
                hold_d    = '0;
                rep_d     = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
                rep_d  = rep_q;
            end
        end
`endif

        step_d   = fire_step;
        cpuclk_d = cpuclk_q;
        pulse_d  = pulse_q;
        count_d  = count_q;
        if (fire_step) begin
            cpuclk_d = 1'b1;
            pulse_d  = PULSE_W'(PULSE_CYCLES - 1);
            count_d  = count_q + 16'd1;
        end else if (cpuclk_q) begin
            if (pulse_q == '0) begin
                cpuclk_d = 1'b0;
            end else begin
                pulse_d = pulse_q - PULSE_W'(1);
            end
        end

        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // State and output registers; async reset drops CPUCLK and aborts any pulse.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            pulse_q  <= '0;
            cpuclk_q <= 1'b0;
            step_q   <= 1'b0;
            level_q  <= 1'b0;
            count_q  <= '0;
`ifdef STEP_AUTOREPEAT_EN
            hold_q   <= '0;
            rep_q    <= 1'b0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            cpuclk_q <= cpuclk_d;
            step_q   <= step_d;
            level_q  <= level_d;
            count_q  <= count_d;
`ifdef STEP_AUTOREPEAT_EN
            hold_q   <= hold_d;
            rep_q    <= rep_d;
`endif
        end
    end

    assign CPUCLK      = cpuclk_q;
    assign StepPulse   = step_q;
    assign ButtonLevel = level_q;
    assign StepCount   = count_q;

endmodule

// File: tb/tb_step_clk_debouncer.sv
// Directed bench for step_clk_debouncer with small debounce/pulse parameters.
module tb_step_clk_debouncer;

    logic        clk;
    logic        rst_n;
    logic        button;
    logic        cpuclk;
    logic        step_pulse;
    logic        level;
    logic [15:0] step_count;

    int unsigned n_tests;
    int unsigned n_fail;

`ifdef STEP_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    step_clk_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .PULSE_CYCLES   (2),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .CLK        (clk),
        .Reset_n    (rst_n),
        .Button     (button),
        .CPUCLK     (cpuclk),
        .StepPulse  (step_pulse),
        .ButtonLevel(level),
        .StepCount  (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned pulses;
    int          pulse_edge;
    logic        bounce_v [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        button  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cpuclk", 32'(cpuclk), 32'd0);
        check("rst_step", 32'(step_pulse), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Clean press: pulse after edge 6, CPUCLK high edges 6..7
        button = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("clean_step_e%0d", k), 32'(step_pulse), 32'(k == 6));
            check($sformatf("clean_clk_e%0d", k), 32'(cpuclk), 32'(k == 6 || k == 7));
        end
        check("clean_count", 32'(step_count), 32'd1);
        check("clean_level", 32'(level), 32'd1);

        // Keep holding to edge 46: auto-repeat adds steps at 16,21,...,46
        pulses = 0;
        for (int k = 12; k <= 46; k++) begin
            tick();
            if (step_pulse) pulses++;
        end
        check("hold_pulses", pulses, AUTOREP ? 32'd7 : 32'd0);
        check("hold_count", 32'(step_count), AUTOREP ? 32'd8 : 32'd1);

        // Release: level drops, no step on release
        button = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (step_pulse) pulses++;
        end
        check("release_pulses", pulses, 32'd0);
        check("release_level", 32'(level), 32'd0);
        check("release_count", 32'(step_count), AUTOREP ? 32'd8 : 32'd1);

        // Reset mid-pulse
        button = 1'b1;
        repeat (7) tick();
        check("midpulse_cpuclk_hi", 32'(cpuclk), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_cpuclk", 32'(cpuclk), 32'd0);
        check("async_rst_step", 32'(step_pulse), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_count", 32'(step_count), 32'd0);
        button = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_cpuclk", 32'(cpuclk), 32'd0);

        // Bouncy press 1,0,1,0,1 then steady 1; the last value lands before rel edge 0
        bounce_v[0] = 1'b1; bounce_v[1] = 1'b0; bounce_v[2] = 1'b1;
        bounce_v[3] = 1'b0; bounce_v[4] = 1'b1;
        pulses     = 0;
        pulse_edge = -100;
        for (int i = 0; i < 5; i++) begin
            button = bounce_v[i];
            tick();
            if (step_pulse) begin
                pulses++;
                pulse_edge = i - 4;
            end
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (step_pulse) begin
                pulses++;
                pulse_edge = k;
            end
        end
        check("bounce_pulses", pulses, 32'd1);
        check("bounce_edge", 32'(pulse_edge), 32'd6);
        check("bounce_count", 32'(step_count), 32'd1);

        // Release bounce while PRESSED: 0 for two cycles, then 1 again
        button = 1'b0;
        repeat (2) tick();
        button = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (step_pulse) pulses++;
            check($sformatf("relbounce_level_%0d", k), 32'(level), 32'd1);
        end
        check("relbounce_pulses", pulses, 32'd0);
        check("relbounce_count", 32'(step_count), 32'd1);
        button = 1'b0;
        repeat (12) tick();
        check("relbounce_idle_level", 32'(level), 32'd0);

        // Counter wrap: preload 0xFFFF, next press wraps to 0
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        tick();
        check("wrap_preload", 32'(step_count), 32'h0000FFFF);
        button = 1'b1;
        repeat (7) tick();
        check("wrap_step", 32'(step_pulse), 32'd1);
        check("wrap_count", 32'(step_count), 32'd0);
        button = 1'b0;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
